// File: rtl/apu_dispatcher.sv
// Core-side initiator of the APU request/response interface: queues vector
// instructions, issues them one at a time and returns scalar results.
module apu_dispatcher #(
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr_word,
    input  logic [31:0] instr_rs1_val,
    input  logic [31:0] instr_rs2_val,
    input  logic [5:0]  instr_op,
    input  logic [14:0] instr_flags,
    input  logic [4:0]  instr_rd_addr,
    input  logic        instr_rd_we,
    output logic        apu_req,
    input  logic        apu_gnt,
    output logic [31:0] apu_operands [2:0],
    output logic [5:0]  apu_op,
    output logic [14:0] apu_flags,
    input  logic        apu_rvalid,
    input  logic [31:0] apu_result,
    output logic        wb_valid,
    output logic [4:0]  wb_rd_addr,
    output logic [31:0] wb_data,
    output logic        busy,
    output logic        timeout_err,
    output logic        spurious_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [TW-1:0] TMO_ONE  = {{(TW-1){1'b0}}, 1'b1};
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic [31:0] word;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [5:0]  op;
        logic [14:0] flags;
        logic [4:0]  rd_addr;
        logic        rd_we;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    entry_t        mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    state_e        state_q;
    logic [TW-1:0] tmo_cnt_q;
    logic [4:0]    rd_addr_q;
    logic          rd_we_q;
    logic          wb_valid_q;
    logic [4:0]    wb_rd_addr_q;
    logic [31:0]   wb_data_q;
    logic          timeout_q;
    logic          spurious_q;

    logic          push_s;
    logic          pop_s;
    logic          fifo_empty_s;
    entry_t        head_s;

    // Occupancy is the registered count only, so a same-cycle pop never frees a slot
    assign push_s       = instr_valid & (count_q != FULL_CNT);
    assign pop_s        = (state_q == REQ) & apu_gnt;
    assign fifo_empty_s = (count_q == {CW{1'b0}});
    assign head_s       = mem_q[rd_ptr_q];

    assign instr_ready  = (count_q != FULL_CNT);
    assign apu_req      = (state_q == REQ);
    assign busy         = (state_q != IDLE) | ~fifo_empty_s;
    assign wb_valid     = wb_valid_q;
    assign wb_rd_addr   = wb_rd_addr_q;
    assign wb_data      = wb_data_q;
    assign timeout_err  = timeout_q;
    assign spurious_err = spurious_q;

    // Present the queue head while requesting, zero otherwise
    always_comb begin
        if (state_q == REQ) begin
            apu_operands[0] = head_s.word;
            apu_operands[1] = head_s.rs1;
            apu_operands[2] = head_s.rs2;
            apu_op          = head_s.op;
            apu_flags       = head_s.flags;
        end else begin
            apu_operands[0] = 32'h0000_0000;
            apu_operands[1] = 32'h0000_0000;
            apu_operands[2] = 32'h0000_0000;
            apu_op          = 6'd0;
            apu_flags       = 15'd0;
        end
    end

    // Instruction FIFO storage, pointers and occupancy
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {ENTRY_W{1'b0}};
            end
        end else begin
            if (push_s) begin
                mem_q[wr_ptr_q] <= {instr_word, instr_rs1_val, instr_rs2_val, instr_op,
                                    instr_flags, instr_rd_addr, instr_rd_we};
                wr_ptr_q        <= wr_ptr_q + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    // Dispatch FSM with in-flight tracking, response timeout and registered status pulses
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q      <= IDLE;
            tmo_cnt_q    <= {TW{1'b0}};
            rd_addr_q    <= 5'd0;
            rd_we_q      <= 1'b0;
            wb_valid_q   <= 1'b0;
            wb_rd_addr_q <= 5'd0;
            wb_data_q    <= 32'h0000_0000;
            timeout_q    <= 1'b0;
            spurious_q   <= 1'b0;
        end else begin
            wb_valid_q <= 1'b0;
            timeout_q  <= 1'b0;
            spurious_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    spurious_q <= apu_rvalid;
                    if (!fifo_empty_s) begin
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    spurious_q <= apu_rvalid;
                    if (apu_gnt) begin
                        rd_addr_q <= head_s.rd_addr;
                        rd_we_q   <= head_s.rd_we;
                        tmo_cnt_q <= {TW{1'b0}};
                        state_q   <= RESP;
                    end
                end
                RESP: begin
                    // A completion in the final counted cycle still beats the timeout
                    if (apu_rvalid) begin
                        if (rd_we_q) begin
                            wb_valid_q   <= 1'b1;
                            wb_rd_addr_q <= rd_addr_q;
                            wb_data_q    <= apu_result;
                        end
                        state_q <= fifo_empty_s ? IDLE : REQ;
                    end else if (tmo_cnt_q == TMO_LAST) begin
                        timeout_q <= 1'b1;
                        state_q   <= IDLE;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + TMO_ONE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apu_dispatcher.sv
// Self-checking bench for apu_dispatcher: directed scenarios plus a randomized
// responder checked against a transaction-level queue model.
module tb_apu_dispatcher;

    localparam int DEPTH = 4;
    localparam int TMO   = 64;

    logic        clk = 1'b0;
    logic        n_reset;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_word;
    logic [31:0] instr_rs1_val;
    logic [31:0] instr_rs2_val;
    logic [5:0]  instr_op;
    logic [14:0] instr_flags;
    logic [4:0]  instr_rd_addr;
    logic        instr_rd_we;
    logic        apu_req;
    logic        apu_gnt;
    logic [31:0] apu_operands [2:0];
    logic [5:0]  apu_op;
    logic [14:0] apu_flags;
    logic        apu_rvalid;
    logic [31:0] apu_result;
    logic        wb_valid;
    logic [4:0]  wb_rd_addr;
    logic [31:0] wb_data;
    logic        busy;
    logic        timeout_err;
    logic        spurious_err;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [31:0] word;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [5:0]  op;
        logic [14:0] flags;
        logic [4:0]  rd;
        logic        we;
    } ent_t;

    // Instructions accepted by the dispatcher but not yet granted
    ent_t fifo_m [$];

    apu_dispatcher #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .n_reset(n_reset),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_word(instr_word), .instr_rs1_val(instr_rs1_val), .instr_rs2_val(instr_rs2_val),
        .instr_op(instr_op), .instr_flags(instr_flags),
        .instr_rd_addr(instr_rd_addr), .instr_rd_we(instr_rd_we),
        .apu_req(apu_req), .apu_gnt(apu_gnt), .apu_operands(apu_operands),
        .apu_op(apu_op), .apu_flags(apu_flags),
        .apu_rvalid(apu_rvalid), .apu_result(apu_result),
        .wb_valid(wb_valid), .wb_rd_addr(wb_rd_addr), .wb_data(wb_data),
        .busy(busy), .timeout_err(timeout_err), .spurious_err(spurious_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One phase of traffic: the bench is the core and the responder; every cycle
    // it compares the DUT against the queue model.
    task automatic run_phase(input int npush, input int push_pct, input int gnt_dly,
                             input int rsp_lat, input int we_pct, input bit spur,
                             input int budget);
        ent_t        pe;
        ent_t        ie;
        logic [31:0] res;
        bit          infl = 1'b0;
        bit          did_push, did_gnt, did_rv, did_spur, exp_wb, exp_to, done;
        int          pushed = 0, cyc = 0, hold = 0, target = 0, wait_c = 0, age = 0, stall = 0;
        done   = 1'b0;
        res    = 32'h0;
        ie     = '0;
        target = (gnt_dly < 0) ? int'($urandom_range(0, 3)) : gnt_dly;
        while (!done && cyc < budget) begin
            did_push = 1'b0; did_gnt = 1'b0; did_rv = 1'b0; did_spur = 1'b0;
            instr_valid = 1'b0; apu_gnt = 1'b0; apu_rvalid = 1'b0;
            if (pushed < npush && int'($urandom_range(0, 99)) < push_pct) begin
                pe.word  = $urandom();
                pe.rs1   = $urandom();
                pe.rs2   = $urandom();
                pe.op    = 6'($urandom());
                pe.flags = 15'($urandom());
                pe.rd    = 5'($urandom());
                pe.we    = (int'($urandom_range(0, 99)) < we_pct);
                instr_word = pe.word; instr_rs1_val = pe.rs1; instr_rs2_val = pe.rs2;
                instr_op = pe.op; instr_flags = pe.flags;
                instr_rd_addr = pe.rd; instr_rd_we = pe.we;
                instr_valid = 1'b1;
                if (fifo_m.size() < DEPTH) begin
                    did_push = 1'b1;
                    pushed++;
                end
            end
            if (apu_req && !infl) begin
                chk("req_queue_nonempty", 64'(fifo_m.size() != 0), 64'd1);
                if (fifo_m.size() != 0) begin
                    chk("operand0", 64'(apu_operands[0]), 64'(fifo_m[0].word));
                    chk("operand1", 64'(apu_operands[1]), 64'(fifo_m[0].rs1));
                    chk("operand2", 64'(apu_operands[2]), 64'(fifo_m[0].rs2));
                    chk("apu_op", 64'(apu_op), 64'(fifo_m[0].op));
                    chk("apu_flags", 64'(apu_flags), 64'(fifo_m[0].flags));
                    if (hold >= target) begin
                        apu_gnt = 1'b1;
                        did_gnt = 1'b1;
                    end else begin
                        hold++;
                    end
                end
            end else if (!apu_req && gnt_dly < 0) begin
                apu_gnt = 1'($urandom_range(0, 1));
            end
            if (infl) begin
                if (wait_c == 0) begin
                    res = $urandom();
                    apu_result = res;
                    apu_rvalid = 1'b1;
                    did_rv = 1'b1;
                end else begin
                    wait_c--;
                end
            end else if (spur && $urandom_range(0, 19) == 0) begin
                apu_result = $urandom();
                apu_rvalid = 1'b1;
                did_spur = 1'b1;
            end
            tick();
            exp_wb = 1'b0;
            exp_to = 1'b0;
            if (did_push) fifo_m.push_back(pe);
            if (did_gnt) begin
                ie     = fifo_m.pop_front();
                infl   = 1'b1;
                age    = 0;
                hold   = 0;
                wait_c = (rsp_lat < 0) ? int'($urandom_range(0, 4)) : rsp_lat;
                target = (gnt_dly < 0) ? int'($urandom_range(0, 3)) : gnt_dly;
            end else if (did_rv) begin
                infl   = 1'b0;
                exp_wb = ie.we;
            end else if (infl) begin
                age++;
                if (age == TMO) begin
                    exp_to = 1'b1;
                    infl   = 1'b0;
                end
            end
            chk("wb_valid", 64'(wb_valid), 64'(exp_wb));
            if (exp_wb) begin
                chk("wb_rd_addr", 64'(wb_rd_addr), 64'(ie.rd));
                chk("wb_data", 64'(wb_data), 64'(res));
            end
            chk("timeout_err", 64'(timeout_err), 64'(exp_to));
            chk("spurious_err", 64'(spurious_err), 64'(did_spur));
            chk("instr_ready", 64'(instr_ready), 64'(fifo_m.size() < DEPTH));
            chk("busy", 64'(busy), 64'(fifo_m.size() != 0 || infl));
            if (infl) chk("req_in_resp", 64'(apu_req), 64'd0);
            if (fifo_m.size() != 0 && !infl && !apu_req) begin
                stall++;
                chk("req_latency", 64'(stall > 1), 64'd0);
            end else begin
                stall = 0;
            end
            cyc++;
            done = (pushed >= npush) && (fifo_m.size() == 0) && !infl;
        end
        instr_valid = 1'b0; apu_gnt = 1'b0; apu_rvalid = 1'b0;
        chk("phase_drained", 64'(done), 64'd1);
    endtask

    initial begin
        n_reset = 1'b0;
        instr_valid = 1'b0; instr_word = 32'h0; instr_rs1_val = 32'h0; instr_rs2_val = 32'h0;
        instr_op = 6'd0; instr_flags = 15'd0; instr_rd_addr = 5'd0; instr_rd_we = 1'b0;
        apu_gnt = 1'b0; apu_rvalid = 1'b0; apu_result = 32'h0;
        tick();
        tick();
        chk("rst_instr_ready", 64'(instr_ready), 64'd1);
        chk("rst_apu_req", 64'(apu_req), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_wb_valid", 64'(wb_valid), 64'd0);
        chk("rst_timeout", 64'(timeout_err), 64'd0);
        chk("rst_spurious", 64'(spurious_err), 64'd0);
        chk("rst_operand0", 64'(apu_operands[0]), 64'd0);
        n_reset = 1'b1;
        tick();

        // Single vsetvli with an immediate-grant, single-cycle responder
        instr_valid = 1'b1; instr_word = 32'h0C05_72D7; instr_rs1_val = 32'd100;
        instr_rs2_val = 32'd0; instr_op = 6'd3; instr_flags = 15'd7;
        instr_rd_addr = 5'd5; instr_rd_we = 1'b1;
        tick();
        chk("t1_req_after_push", 64'(apu_req), 64'd0);
        chk("t1_busy", 64'(busy), 64'd1);
        instr_valid = 1'b0;
        tick();
        chk("t1_req", 64'(apu_req), 64'd1);
        chk("t1_operand0", 64'(apu_operands[0]), 64'h0C05_72D7);
        chk("t1_operand1", 64'(apu_operands[1]), 64'd100);
        apu_gnt = 1'b1;
        tick();
        chk("t1_req_drop", 64'(apu_req), 64'd0);
        apu_gnt = 1'b0; apu_rvalid = 1'b1; apu_result = 32'd16;
        tick();
        apu_rvalid = 1'b0;
        chk("t1_wb_valid", 64'(wb_valid), 64'd1);
        chk("t1_wb_rd", 64'(wb_rd_addr), 64'd5);
        chk("t1_wb_data", 64'(wb_data), 64'd16);
        chk("t1_busy_done", 64'(busy), 64'd0);
        tick();
        chk("t1_wb_once", 64'(wb_valid), 64'd0);

        // Three back-to-back non-writeback instructions, zero-latency responder
        run_phase(3, 100, 0, 0, 0, 1'b0, 50);
        // Grant withheld for five cycles while the core keeps pushing until full
        run_phase(8, 100, 5, 0, 50, 1'b0, 150);
        // Responder never completes: both queued instructions time out
        run_phase(2, 100, 0, 1000, 50, 1'b0, 400);
        // Completion in the very last counted cycle beats the timeout
        run_phase(1, 100, 0, TMO - 1, 100, 1'b0, 150);

        // Completion pulse with nothing outstanding
        apu_rvalid = 1'b1; apu_result = 32'hDEAD_BEEF;
        tick();
        apu_rvalid = 1'b0;
        chk("t5_spurious", 64'(spurious_err), 64'd1);
        chk("t5_no_wb", 64'(wb_valid), 64'd0);
        chk("t5_busy", 64'(busy), 64'd0);
        tick();
        chk("t5_spurious_once", 64'(spurious_err), 64'd0);
        chk("t5_idle", 64'(apu_req), 64'd0);

        // Randomized traffic with random grant/response latencies and stray completions
        run_phase(40, 40, -1, -1, 50, 1'b1, 3000);

        // Reset while an instruction is in flight with two more queued
        instr_valid = 1'b1; instr_rd_we = 1'b1; instr_rd_addr = 5'd3; instr_word = 32'h0000_00A0;
        tick();
        instr_word = 32'h0000_00B0;
        tick();
        chk("t6_req", 64'(apu_req), 64'd1);
        instr_word = 32'h0000_00C0; apu_gnt = 1'b1;
        tick();
        instr_valid = 1'b0; apu_gnt = 1'b0;
        chk("t6_in_resp", 64'(apu_req), 64'd0);
        chk("t6_busy", 64'(busy), 64'd1);
        n_reset = 1'b0;
        #1;
        chk("t6_rst_ready", 64'(instr_ready), 64'd1);
        chk("t6_rst_busy", 64'(busy), 64'd0);
        chk("t6_rst_req", 64'(apu_req), 64'd0);
        apu_rvalid = 1'b1; apu_result = 32'h1234_5678;
        tick();
        apu_rvalid = 1'b0;
        n_reset = 1'b1;
        fifo_m.delete();
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t6_post_req", 64'(apu_req), 64'd0);
            chk("t6_post_wb", 64'(wb_valid), 64'd0);
            chk("t6_post_ready", 64'(instr_ready), 64'd1);
            chk("t6_post_busy", 64'(busy), 64'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
